// File: rtl/block_minmax.sv
// rtl/block_minmax.sv - collects a 32-pixel RGBA block with running per-channel min/max
//
// Purpose: front-end stage of the compression pipeline. Accepts one pixel per
// beat, keeps running per-channel min/max, and presents the whole block plus
// header, maxima and compressable flag as a single output beat.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready pixel handshake, in_pixel = {R, G, B, A}
//   out_valid/out_ready block handshake
//   out_pixels        channel-planar block: {r_channel, g_channel, b_channel, a_channel},
//                     each plane PIXELS bytes with element k at byte k of the plane
//   out_header        {skip_r, skip_g, skip_b, skip_a, r_min, g_min, b_min, a_min, 12'h000}
//   out_max           {r_max, g_max, b_max, a_max}
//   out_compressable  every channel range fits in RES_BITS bits
module block_minmax #(
  parameter int PIXELS   = 32,
  parameter int RES_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXELS*32-1:0]   out_pixels,
  output logic [47:0]            out_header,
  output logic [31:0]            out_max,
  output logic                   out_compressable
);

  localparam int PLANE = PIXELS * 8;
  localparam logic [4:0] LAST_BEAT = 5'(PIXELS - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  logic [4:0] count;
  logic       accept;
  logic       last_beat;

  // Channel index 0..3 = R, G, B, A throughout.
  logic [7:0] v     [4];
  logic [7:0] min_q [4];
  logic [7:0] max_q [4];
  logic [7:0] min_d [4];
  logic [7:0] max_d [4];
  logic [7:0] diff  [4];
  logic [3:0] skip;
  logic       fits;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; in_ready is forced low while reset is held
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = !rst;
        if (in_valid && !rst && count == LAST_BEAT) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (count == LAST_BEAT);

  // Running min/max including the current pixel; beat 0 restarts from the
  // pixel itself so nothing leaks in from the previous block.
  always_comb begin
    fits = 1'b1;
    skip = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      v[c] = in_pixel[31-8*c -: 8];
      if (count == 5'd0) begin
        min_d[c] = v[c];
        max_d[c] = v[c];
      end else begin
        min_d[c] = (v[c] < min_q[c]) ? v[c] : min_q[c];
        max_d[c] = (v[c] > max_q[c]) ? v[c] : max_q[c];
      end
      diff[c]     = max_d[c] - min_d[c];
      skip[3 - c] = (min_d[c] == max_d[c]);
      if ({1'b0, diff[c]} >= 9'(1 << RES_BITS)) begin
        fits = 1'b0;
      end
    end
  end

  // Datapath. Pixels are written straight into the output register while
  // filling; out_valid is low then, and HOLD never accepts, so the block is
  // stable for the whole time it is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      count            <= 5'd0;
      out_pixels       <= '0;
      out_header       <= '0;
      out_max          <= '0;
      out_compressable <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        min_q[c] <= 8'h00;
        max_q[c] <= 8'h00;
      end
    end else if (accept) begin
      count <= count + 5'd1;  // wraps to 0 after the last beat
      for (int c = 0; c < 4; c++) begin
        out_pixels[(3-c)*PLANE + 8*int'(count) +: 8] <= v[c];
        min_q[c] <= min_d[c];
        max_q[c] <= max_d[c];
      end
      if (last_beat) begin
        out_header       <= {skip, min_d[0], min_d[1], min_d[2], min_d[3], 12'h000};
        out_max          <= {max_d[0], max_d[1], max_d[2], max_d[3]};
        out_compressable <= fits;
      end
    end
  end

endmodule

// File: tb/tb_block_minmax.sv
// tb/tb_block_minmax.sv - self-checking bench for block_minmax
module tb_block_minmax;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pixel = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1023:0] out_pixels;
  logic [47:0]   out_header;
  logic [31:0]   out_max;
  logic          out_compressable;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  block_minmax #(.PIXELS(32), .RES_BITS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_pixel         (in_pixel),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pixels       (out_pixels),
    .out_header       (out_header),
    .out_max          (out_max),
    .out_compressable (out_compressable)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic          m_live = 1'b0;
  logic          m_hold = 1'b0;
  logic [31:0]   m_q[$];
  logic [1023:0] e_pix = '0;
  logic [47:0]   e_hdr = '0;
  logic [31:0]   e_max = '0;
  logic          e_comp = 1'b0;
  int            bad;

  task automatic compute_block();
    logic [7:0] mn, mx, v;
    logic [3:0] sk;
    logic       comp;
    comp  = 1'b1;
    e_pix = '0;
    for (int c = 0; c < 4; c++) begin
      mn = 8'hFF;
      mx = 8'h00;
      for (int k = 0; k < 32; k++) begin
        v = m_q[k][31-8*c -: 8];
        e_pix[(3-c)*256 + 8*k +: 8] = v;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      sk[3-c] = (mn == mx);
      if ((mx - mn) >= 8'd16) comp = 1'b0;
      e_hdr[43-8*c -: 8] = mn;
      e_max[31-8*c -: 8] = mx;
    end
    e_hdr[47:44] = sk;
    e_hdr[11:0]  = 12'h000;
    e_comp       = comp;
  endtask

  // Compare DUT against the model, then advance the model with the inputs
  // that will be sampled at the coming rising edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 64'(in_ready), 64'(rst ? 1'b0 : !m_hold));
      chk("out_valid", 64'(out_valid), 64'(m_hold));
      chk("out_header", 64'(out_header), 64'(e_hdr));
      chk("out_max", 64'(out_max), 64'(e_max));
      chk("out_compressable", 64'(out_compressable), 64'(e_comp));
      if (m_hold) begin
        total++;
        if (out_pixels === e_pix) passed++;
        else begin
          bad = 0;
          for (int i = 127; i >= 0; i--)
            if (out_pixels[8*i +: 8] !== e_pix[8*i +: 8]) bad = i;
          $display("FAIL out_pixels byte %0d: got %h expected %h",
                   bad, out_pixels[8*bad +: 8], e_pix[8*bad +: 8]);
        end
      end
    end
    if (rst) begin
      m_live = 1'b1;
      m_hold = 1'b0;
      m_q.delete();
      e_pix  = '0;
      e_hdr  = '0;
      e_max  = '0;
      e_comp = 1'b0;
    end else if (m_live) begin
      if (!m_hold && in_valid) begin
        m_q.push_back(in_pixel);
        if (m_q.size() == 32) begin
          compute_block();
          m_hold = 1'b1;
          m_q.delete();
        end
      end else if (m_hold && out_ready) begin
        m_hold = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] blk[32];
  bit          ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p, input int gap);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_pixel = p;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 200 cycles", in_ready);
    end
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_block(input bit gaps);
    for (int k = 0; k < 32; k++)
      send(blk[k], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) begin
      total++;
      $display("FAIL wait_out_valid: out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic release_block();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic threshold(input logic [7:0] lo, input logic [7:0] hi, input logic expc, input string name);
    for (int k = 0; k < 32; k++) blk[k] = {(k % 2 == 1) ? hi : lo, 24'h808080};
    send_block(1'b0);
    wait_valid(ok);
    if (ok) chk(name, 64'(out_compressable), 64'(expc));
    release_block();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;

    // constant block
    for (int k = 0; k < 32; k++) blk[k] = 32'h10203040;
    send_block(1'b0);
    wait_valid(ok);
    if (ok) begin
      chk("const_header", 64'(out_header), 64'({4'hF, 32'h10203040, 12'h000}));
      chk("const_max", 64'(out_max), 64'(32'h10203040));
      chk("const_comp", 64'(out_compressable), 64'(1'b1));
      chk("const_r_channel0", 64'(out_pixels[768 +: 8]), 64'(8'h10));
      chk("const_a_channel31", 64'(out_pixels[248 +: 8]), 64'(8'h40));
    end
    release_block();

    // R ramp
    for (int k = 0; k < 32; k++) blk[k] = {8'(k), 24'h808080};
    send_block(1'b0);
    wait_valid(ok);
    if (ok) begin
      chk("ramp_r_min", 64'(out_header[43:36]), 64'(8'h00));
      chk("ramp_g_min", 64'(out_header[35:28]), 64'(8'h80));
      chk("ramp_r_max", 64'(out_max[31:24]), 64'(8'd31));
      chk("ramp_skip", 64'(out_header[47:44]), 64'(4'b0111));
      chk("ramp_comp", 64'(out_compressable), 64'(1'b0));
      chk("ramp_r_channel5", 64'(out_pixels[768 + 8*5 +: 8]), 64'(8'd5));
      chk("ramp_r_channel31", 64'(out_pixels[768 + 8*31 +: 8]), 64'(8'd31));
    end
    release_block();

    // compressable threshold
    threshold(8'h50, 8'h5F, 1'b1, "thr_0f_comp");
    threshold(8'h50, 8'h60, 1'b0, "thr_10_comp");
    threshold(8'h00, 8'hFF, 1'b0, "thr_ff_comp");

    // backpressure with ignored in_valid pulses in HOLD
    for (int k = 0; k < 32; k++) blk[k] = $urandom;
    send_block(1'b0);
    wait_valid(ok);
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = (i % 2 == 0);
      in_pixel = $urandom;
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(1'b0));
      chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_out_valid", 64'(out_valid), 64'(1'b0));
    chk("bp_release_in_ready", 64'(in_ready), 64'(1'b1));
    tick();

    // reset mid-fill
    for (int k = 0; k < 10; k++) send($urandom, 0);
    do_reset();
    for (int k = 0; k < 32; k++) blk[k] = 32'h01010101;
    send_block(1'b0);
    wait_valid(ok);
    if (ok) begin
      chk("rstfill_header", 64'(out_header), 64'({4'hF, 32'h01010101, 12'h000}));
      chk("rstfill_pixels", 64'(out_pixels === {128{8'h01}}), 64'(1'b1));
    end

    // reset while holding drops the block
    tick();
    do_reset();
    @(negedge clk);
    chk("rsthold_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rsthold_in_ready", 64'(in_ready), 64'(1'b1));
    chk("rsthold_header", 64'(out_header), 64'(48'h0));
    tick();

    // back-to-back with gaps, out_ready held high early
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) blk[k] = 32'h00000000;
    send_block(1'b1);
    for (int k = 0; k < 32; k++) blk[k] = 32'hFFFFFFFF;
    send_block(1'b1);
    wait_valid(ok);
    if (ok) begin
      chk("b2b_header", 64'(out_header), 64'({4'hF, 32'hFFFFFFFF, 12'h000}));
      chk("b2b_max", 64'(out_max), 64'(32'hFFFFFFFF));
    end
    for (int k = 0; k < 32; k++) blk[k] = $urandom;
    send_block(1'b1);
    wait_valid(ok);
    tick();
    out_ready = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/block_minmax.md
# block_minmax

Front-end stage of the compression pipeline. It collects one 32-pixel RGBA block, one pixel per beat. While pixels arrive it keeps a running per-channel minimum and maximum. When the block is complete it presents the whole block, the 48-bit header (skip flags and per-channel minimums), the per-channel maximums and the compressable flag in a single output beat. The residual stage consumes this output directly: these are the `pixels`, `header`, `compressable` and `max_pixels` fields of `types::header_residual_reg`.

## Interface
Parameters:
- `PIXELS`, 32: pixels per block; fixed by `types::pixels_t`. No other value is supported.
- `RES_BITS`, 4: residual width that qualifies a block as compressable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_pixel` is valid.
- `in_ready`  out  1  stage accepts a pixel this cycle.
- `in_pixel`  in  32  bits [31:24]=R, [23:16]=G, [15:8]=B, [7:0]=A.
- `out_valid`  out  1  output block is valid.
- `out_ready`  in  1  downstream accepts the block.
- `out_pixels`  out  `types::pixels_t` (1024)  the collected block.
- `out_header`  out  `types::header_t` (48)  skip flags, minimums and pad.
- `out_max`  out  32  {r_max, g_max, b_max, a_max}.
- `out_compressable`  out  1  block fits `RES_BITS` residuals.

## Operation
- FSM states: FILL, HOLD.
- FILL:
  - `in_ready`=1.
  - A beat is accepted when `in_valid & in_ready`.
  - Accepted beat k (k = 0..31, held in a 5-bit counter) writes the channel view of the block: `r_channel[k]`, `g_channel[k]`, `b_channel[k]`, `a_channel[k]`.
  - Beat 0 loads min = max = that pixel's channel values. No stale state is carried from the previous block.
  - Beats 1..31 update each channel: min = min(min, v), max = max(max, v). Comparisons are unsigned 8-bit.
- When beat 31 is accepted, the output registers load in the same edge:
  - Final min/max include pixel 31.
  - `skip_x` = (min_x == max_x) for each channel.
  - Header min fields = min_x.
  - pad = 12'h000.
  - `out_compressable` = 1 iff (max_x − min_x) < 2^`RES_BITS` for all four channels. The subtraction is 8-bit unsigned and never negative.
  - FSM moves to HOLD; the counter wraps to 0.
- HOLD:
  - `in_ready`=0; `out_valid`=1.
  - All outputs are held stable until `out_ready`.
  - On `out_valid & out_ready`: go to FILL, drop `out_valid` the next cycle.
  - `in_ready` returns to 1 in the cycle after the handoff.
- `in_valid` while `in_ready`=0 is ignored. The upstream must hold its pixel.
- Header raw bit map:
  - 47 skip_r, 46 skip_g, 45 skip_b, 44 skip_a.
  - 43:36 r_min, 35:28 g_min, 27:20 b_min, 19:12 a_min.
  - 11:0 pad.

## Timing
- Reset (cycle with `rst`=1):
  - State → FILL, counter → 0.
  - `out_valid` → 0.
  - `out_pixels`, `out_header`, `out_max` and `out_compressable` → all zero.
  - `in_ready`=0 during the reset cycle and 1 from the first cycle after.
- Reset mid-FILL discards the partial block. The next accepted beat is beat 0.
- Reset in HOLD drops the pending block without a handshake.
- Latency: `out_valid` rises the cycle after beat 31 is accepted.
- Throughput: minimum 33 cycles per block (32 fill beats plus 1 handoff cycle). There is no overlap between FILL and HOLD.
- `in_valid` gaps during FILL stall the counter. Min/max update only on accepted beats.
- `out_ready` high before `out_valid` does not affect the block. The handoff completes on the first `out_valid` cycle.

## Test plan
- Constant block, all 32 pixels 0x10203040:
  - skip_r/g/b/a = 1; mins = 0x10, 0x20, 0x30, 0x40; `out_max` = 0x10203040; compressable = 1.
  - header raw = {4'hF, 32'h10203040, 12'h000}.
- R ramp: R = 0..31 at beat k, G/B/A fixed at 0x80:
  - r_min = 0, r_max = 31, skip_r = 0, skip_g/b/a = 1; compressable = 0.
  - `r_channel[k]` = k.
- Threshold: R alternates 0x50/0x5F → compressable = 1. Same test with R alternating 0x50/0x60 → compressable = 0. Min = 0x00 with max = 0xFF → compressable = 0.
- Backpressure:
  - `out_ready` held 0 for 10 cycles after `out_valid`: outputs are bit-stable and `in_ready`=0.
  - `in_valid` pulses during HOLD are not captured.
  - Release `out_ready`: `out_valid` falls the next cycle and `in_ready` rises.
- Reset after 10 beats, then 32 new beats of 0x01010101 → block is all 0x01010101 and mins = 1. The earlier pixels do not appear in the block or in min/max.
- Back-to-back blocks with random `in_valid` gaps:
  - Block B min/max are independent of block A, e.g. A all 0x00, B all 0xFF → B mins = 0xFF.
  - Pixel positions match beat order.
